// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle. Divide-by-zero and signed overflow finish one cycle after the start.
module riscv_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] rem_acc_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_mag_r;
    logic [CW-1:0]    count_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             want_rem_r;

    logic             is_signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] spec_res_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    // Operand decode, special-case detection and one restoring step.
    always_comb begin
        is_signed_s = ~op[0];
        a_neg_s     = is_signed_s & dividend[WIDTH-1];
        b_neg_s     = is_signed_s & divisor[WIDTH-1];
        a_mag_s     = a_neg_s ? (~dividend + WIDTH'(1'b1)) : dividend;
        b_mag_s     = b_neg_s ? (~divisor + WIDTH'(1'b1)) : divisor;
        div_zero_s  = (divisor == {WIDTH{1'b0}});
        ovf_s       = is_signed_s
                    & (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    & (divisor == {WIDTH{1'b1}});
        accept_s    = start & ~flush & (state_r != CALC);
        last_s      = (count_r == CW'(WIDTH-1));

        if (div_zero_s) begin
            spec_res_s = op[1] ? dividend : {WIDTH{1'b1}};
        end else if (ovf_s) begin
            spec_res_s = op[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            spec_res_s = {WIDTH{1'b0}};
        end

        // The dividend is shifted out of quo_r MSB-first while quotient bits shift in at the LSB.
        shifted_s = {rem_acc_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, div_mag_r};
        if (diff_s[WIDTH]) begin
            r_next_s = shifted_s[WIDTH-1:0];
            q_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            r_next_s = diff_s[WIDTH-1:0];
            q_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end

        q_fix_s = neg_q_r ? (~q_next_s + WIDTH'(1'b1)) : q_next_s;
        r_fix_s = neg_r_r ? (~r_next_s + WIDTH'(1'b1)) : r_next_s;
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= {WIDTH{1'b0}};
            rem_acc_r  <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            div_mag_r  <= {WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            want_rem_r <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (accept_s) begin
            want_rem_r <= op[1];
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_r_r    <= a_neg_s;
            div_mag_r  <= b_mag_s;
            quo_r      <= a_mag_s;
            rem_acc_r  <= {WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            if (div_zero_s || ovf_s) begin
                state_r <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                result  <= spec_res_s;
            end else begin
                state_r <= CALC;
                busy    <= 1'b1;
                done    <= 1'b0;
            end
        end else begin
            case (state_r)
                CALC: begin
                    rem_acc_r <= r_next_s;
                    quo_r     <= q_next_s;
                    count_r   <= count_r + CW'(1'b1);
                    if (last_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= want_rem_r ? r_fix_s : q_fix_s;
                    end else begin
                        state_r <= CALC;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                IDLE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed bench for riscv_div_unit: an arithmetic reference model with a per-cycle compare.
// Literal expectations from hand calculation are checked alongside the model.
module tb_riscv_div_unit;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'h0;
    logic [31:0] divisor = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_pend = 32'h0;
    int          m_left = 0;

    riscv_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (!o[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    // Timing model: latency 1 for special cases, WIDTH+1 otherwise.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_result <= 32'h0; m_left <= 0;
        end else if (flush) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (start && !m_busy) begin
            if (is_special(op, dividend, divisor)) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_result <= ref_res(op, dividend, divisor);
            end else begin
                m_busy <= 1'b1; m_done <= 1'b0; m_left <= WIDTH;
                m_pend <= ref_res(op, dividend, divisor);
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
        chk("cyc_done", {31'b0, done}, {31'b0, m_done});
        chk("cyc_result", result, m_result);
    end

    // Caller is at a negedge; start is high for exactly one cycle (cycle 0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        dividend = $urandom;
        divisor = $urandom;
    endtask

    // Waits (bounded) for done, starting from cycle first_cyc; returns in the done cycle.
    task automatic wait_done(input int first_cyc, input int exp_lat, input logic [31:0] exp_res,
                             input string name);
        int cyc = first_cyc;
        int bcnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - first_cyc));
        chk({name, "_result"}, result, exp_res);
    endtask

    initial begin
        int dcnt;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        rst_n = 1'b1;

        chk("pin_divu", ref_res(2'b01, 32'd100, 32'd7), 32'd14);
        chk("pin_remu", ref_res(2'b11, 32'd100, 32'd7), 32'd2);
        chk("pin_div_neg", ref_res(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem_neg", ref_res(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_rem_negdiv", ref_res(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
        chk("pin_div0", ref_res(2'b00, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("pin_remu0", ref_res(2'b11, 32'd5, 32'd0), 32'd5);
        chk("pin_rem_ovf", ref_res(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        @(negedge clk); issue(2'b01, 32'd100, 32'd7); wait_done(1, 33, 32'd14, "divu_100_7");
        @(negedge clk); issue(2'b11, 32'd100, 32'd7); wait_done(1, 33, 32'd2, "remu_100_7");

        // Back-to-back: the second start lands in the DONE cycle of the first.
        @(negedge clk); issue(2'b00, 32'hFFFF_FFF9, 32'd2); wait_done(1, 33, 32'hFFFF_FFFD, "div_m7_2");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2); wait_done(1, 33, 32'hFFFF_FFFF, "b2b_rem_m7_2");

        @(negedge clk); issue(2'b10, 32'd7, 32'hFFFF_FFFE); wait_done(1, 33, 32'd1, "rem_7_m2");
        @(negedge clk); issue(2'b00, 32'd5, 32'd0); wait_done(1, 1, 32'hFFFF_FFFF, "div_5_0");
        @(negedge clk); issue(2'b11, 32'd5, 32'd0); wait_done(1, 1, 32'd5, "remu_5_0");
        @(negedge clk); issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1, 1, 32'h8000_0000, "div_ovf");
        @(negedge clk); issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1, 1, 32'h0, "rem_ovf");
        @(negedge clk); issue(2'b01, 32'd0, 32'd9); wait_done(1, 33, 32'd0, "divu_0_9");
        @(negedge clk); issue(2'b01, 32'hFFFF_FFFF, 32'd1); wait_done(1, 33, 32'hFFFF_FFFF, "divu_max_1");
        @(negedge clk); issue(2'b00, 32'h8000_0000, 32'd1); wait_done(1, 33, 32'h8000_0000, "div_min_1");

        // Flush in cycle 10, restart in cycle 11, done in cycle 44.
        @(negedge clk); issue(2'b01, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_done", {31'b0, done}, 32'h0);
        chk("flush_result_held", result, 32'h8000_0000);
        issue(2'b01, 32'd1000, 32'd3); wait_done(12, 44, 32'd333, "after_flush");

        // A start pulse in cycle 5 is ignored.
        @(negedge clk); issue(2'b01, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, 33, 32'd142, "ignored_start");

        // Flush and start together in the DONE cycle: flush wins.
        flush = 1'b1; start = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd0;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'h0);
        chk("flush_start_done", {31'b0, done}, 32'h0);
        chk("flush_start_result", result, 32'd142);

        // Reset in cycle 20 abandons the op with no done pulse afterwards.
        @(negedge clk); issue(2'b01, 32'd77, 32'd5);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_busy", {31'b0, busy}, 32'h0);
        chk("midreset_done", {31'b0, done}, 32'h0);
        chk("midreset_result", result, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("midreset_no_done", 32'(dcnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions; one quotient bit per cycle.
- Sits in the execute stage beside the ALU.
- Its result feeds the 2:1 result-select mux ahead of the EX/MEM register; `done` drives that mux select.
- Hazard logic stalls the pipeline while `busy` is high.

Parameters:
- WIDTH, 32: operand/result width in bits; also the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request a divide; accepted only when busy=0
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
- dividend  input  WIDTH  rs1 value, sampled on the accepting edge
- divisor  input  WIDTH  rs2 value, sampled on the accepting edge
- flush  input  1  abort the current operation (branch mispredict/trap)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse: result valid
- result  output  WIDTH  quotient or remainder per op; held until the next accepted start

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0; internal registers cleared.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States:
  - IDLE: waits for start.
  - CALC: iterating; busy=1.
  - DONE: done=1 for exactly one cycle; busy=0.
  - DONE returns to IDLE unless start is accepted in that cycle.
- Accept rule: start=1 with state IDLE or DONE, flush=0.
  - Operands and op are latched at the accepting edge; later input changes have no effect.
  - start while in CALC is ignored; it is not queued.
- Special cases are resolved at accept, go straight to DONE, latency 1 (done in the cycle after the start cycle):
  - Divisor==0: quotient=all ones (0xFFFFFFFF); remainder=dividend. Applies to signed and unsigned ops.
  - Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- Normal path:
  - Signed ops convert both operands to magnitudes; quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - Unsigned restoring division on a WIDTH+1-bit partial remainder, quotient shifted in MSB-first.
  - Exactly WIDTH cycles in CALC (cycles 1..WIDTH after the start cycle 0).
  - Sign correction is applied on the transition to DONE.
  - done is asserted in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- result is registered and updates only on entry to DONE.
- Back-to-back: start in the DONE cycle is accepted; the next op begins without an IDLE cycle.
- Flush:
  - In CALC or DONE: next state IDLE, busy=0 next cycle, done forced to 0, result unchanged.
  - flush and start in the same cycle: flush wins; start is not accepted.
- Zero dividend needs no special path: it yields 0/0 on the normal path.
- All arithmetic is modulo 2^WIDTH; no other exceptions or flags.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> busy high cycles 1..32, done pulse in cycle 33; results 14 then 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both with done in cycle 1 and busy never high.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
- DIVU started, flush in cycle 10 -> busy low in cycle 11, no done pulse, result keeps its old value; a fresh start in cycle 11 completes normally in cycle 44.
- start pulsed in cycle 5 of an op -> ignored, original result correct.
- rst_n low in cycle 20 -> busy=0, done=0, result=0 next cycle.
- Back-to-back start in the DONE cycle -> second done exactly 33 cycles later.
